btn_conditioner: RTL

Per-button input conditioner that turns raw, bouncing, asynchronous push-button levels into clean, clock-synchronous signals for the lab FSM controllers. For each button it provides:
- a debounced level;
- a single-cycle press pulse, which drives the controllers' `btn1`/`btn2`/`btn3` inputs;
- a single-cycle release pulse.

It sits between the board button pins and any state-machine controller that expects one-cycle button events.

---
 rtl/btn_conditioner.sv | 126 ++++++++++++
 1 files changed

// File: rtl/btn_conditioner.sv
// btn_conditioner: per-button synchronizer + debouncer + edge-event generator.
// Turns raw asynchronous bouncing button levels into clean clock-synchronous
// debounced levels and one-cycle press/release events.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   btn_raw      raw button pins (active-high, asynchronous to clk)
//   btn_level    debounced level per channel
//   btn_pulse    one-cycle press event per channel
//   btn_release  one-cycle release event per channel
//   any_pulse    OR of btn_pulse, aligned with btn_pulse
module btn_conditioner #(
  parameter int unsigned N_BTN           = 3,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1300000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_pulse,
  output logic [N_BTN-1:0] btn_release,
  output logic             any_pulse
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {
    RELEASED      = 2'd0,
    PRESS_CHECK   = 2'd1,
    PRESSED       = 2'd2,
    RELEASE_CHECK = 2'd3
  } state_e;

  logic [N_BTN-1:0] level_nxt;
  logic [N_BTN-1:0] pulse_nxt;
  logic [N_BTN-1:0] release_nxt;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
    logic                   pulse_d, release_d;

    assign s       = sync_q[SYNC_STAGES-1];
    // Count of the current opposite-level run including this cycle's sample.
    assign cnt_inc = cnt_q + CNT_W'(1);

    // Synchronizer chain, state and run counter.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        sync_q  <= '0;
        state_q <= RELEASED;
        cnt_q   <= '0;
      end else begin
        sync_q  <= {sync_q[SYNC_STAGES-2:0], btn_raw[i]};
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    // Next-state: a level change is accepted once DEBOUNCE_CYCLES consecutive
    // opposite samples have been seen; any interruption clears the run.
    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pulse_d   = 1'b0;
      release_d = 1'b0;
      unique case (state_q)
        RELEASED, PRESS_CHECK: begin
          if (!s) begin
            state_d = RELEASED;
            cnt_d   = '0;
          end else if (cnt_inc == CNT_DONE) begin
            state_d = PRESSED;
            cnt_d   = '0;
            pulse_d = 1'b1;
          end else begin
            state_d = PRESS_CHECK;
            cnt_d   = cnt_inc;
          end
        end
        PRESSED, RELEASE_CHECK: begin
          if (s) begin
            state_d = PRESSED;
            cnt_d   = '0;
          end else if (cnt_inc == CNT_DONE) begin
            state_d   = RELEASED;
            cnt_d     = '0;
            release_d = 1'b1;
          end else begin
            state_d = RELEASE_CHECK;
            cnt_d   = cnt_inc;
          end
        end
        default: begin
          state_d = RELEASED;
          cnt_d   = '0;
        end
      endcase
    end

    assign level_nxt[i]   = (state_d == PRESSED) || (state_d == RELEASE_CHECK);
    assign pulse_nxt[i]   = pulse_d;
    assign release_nxt[i] = release_d;
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_level   <= '0;
      btn_pulse   <= '0;
      btn_release <= '0;
      any_pulse   <= 1'b0;
    end else begin
      btn_level   <= level_nxt;
      btn_pulse   <= pulse_nxt;
      btn_release <= release_nxt;
      any_pulse   <= |pulse_nxt;
    end
  end

endmodule
